arrow_spawner: RTL and testbench
================================

// Module: arrow_spawner
// PURPOSE
//  Consumer of the 9-bit LFSR pseudo-random word Rand[8:0]. Turns it into falling arrows
//  for the 4-lane DDR playfield. A tick divider paces scroll steps. On each step the
//  arrow grid shifts one row toward the hit row, and a new top row is spawned from Rand.
//  The row leaving the grid goes to the hit-judge stage downstream.
// PARAMETERS
//  ROWS      8    grid height per lane; row 0 = hit row (bottom), row ROWS-1 = spawn row
//  TICK_DIV  16   clocks per scroll step (>=2)
//  MIN_GAP   2    minimum steps between two spawns (>=1)
// PORTS
//  Clock       in   1        single clock; all state changes on posedge
//  Reset       in   1        synchronous, active-high; clears all state
//  Rand        in   9        LFSR output; sampled only in a step cycle
//  Start       in   1        level; IDLE->RUN
//  Pause       in   1        level; freeze while high
//  Stop        in   1        level; RUN->DRAIN
//  Difficulty  in   2        spawn-rate select, sampled in step cycle
//  Grid        out  4*ROWS   arrow bits, Grid[r*4+l] = lane l, row r
//  Exit        out  4        arrows leaving row 0 on the last step, registered
//  ExitValid   out  1        1-cycle pulse with Exit
//  Running     out  1        high in RUN or DRAIN
//  Done        out  1        1-cycle pulse on DRAIN->IDLE
// BEHAVIOUR
//  Reset: state IDLE; Grid=0, Exit=0, ExitValid=0, Running=0, Done=0, tick cnt=0,
//   gap cnt=MIN_GAP (first step may spawn).
//  States:
//   - IDLE -(Start)-> RUN
//   - RUN -(Pause)-> PAUSE -(!Pause)-> RUN
//   - RUN -(Stop & !Pause)-> DRAIN
//   - DRAIN -(Grid==0 after a step)-> IDLE
//   - Pause is not honoured in DRAIN.
//  Priority in the same cycle: Reset > Pause > Stop. Start is ignored outside IDLE.
//  Tick cnt: increments each cycle in RUN/DRAIN; wraps TICK_DIV-1 -> 0. Step = (cnt==TICK_DIV-1).
//   Cnt holds in PAUSE. Cnt is zeroed on entry to RUN from IDLE.
//   First step occurs TICK_DIV cycles after the Start-sampling edge.
//  Step cycle, all updates on the same edge:
//   - Exit <= row 0; ExitValid <= 1.
//   - row r <= row r+1 for r < ROWS-1.
//   - row ROWS-1 <= spawn row.
//  Spawn row (RUN only; DRAIN spawns 0):
//   - spawn = (Rand[8:2] < THRESH[Difficulty]) && (gap >= MIN_GAP).
//   - THRESH = {32,48,64,96} out of 128.
//   - spawn row = onehot(Rand[1:0]) if spawn, else 4'b0000.
//   - gap <= spawn ? 1 : min(gap+1, MIN_GAP).
//  Non-step cycles: ExitValid=0; Exit holds its last value.
//  DRAIN exit: evaluated on the post-step grid; if zero -> IDLE, Done=1 next cycle.
//   Stop on an empty grid still waits for one step.
//  Stop still high in IDLE has no effect. Start high at DRAIN->IDLE re-enters RUN next cycle.
//  Reset mid-game: returns to IDLE and clears the grid on the next edge. No Exit pulse is emitted.
// STRUCTURE
//  ddr_pkg: LANES=4, state encoding (IDLE/RUN/PAUSE/DRAIN), THRESH table, onehot4 function.
//  Sub-module tick_divider (#TICK_DIV; Clock, Reset, En, Clr -> Step).
//  Grid shift, spawn logic and FSM stay in this module.
// TESTING
//  1. Reset held 3 cycles, then released -> all outputs 0, Running=0. Rand changes do not affect Grid.
//  2. Start pulse, Rand=9'h003, Difficulty=3 (3>>2=0<96) -> after 16 clks Grid row 7 = 4'b1000.
//     After 8 more steps Exit=4'b1000, ExitValid pulse.
//  3. Rand held 9'h000, MIN_GAP=2 -> spawns on every 2nd step only (lane 0). Gap pattern 1,0,1,0 in row 7.
//  4. Difficulty=0, Rand=9'h080 (32, not <32) -> no spawn. Rand=9'h07C (31) -> spawn, lane 0.
//  5. Pause high for 40 clks mid-RUN -> Grid, tick cnt frozen. Step resumes where it left off.
//  6. Stop with arrows in rows 7 and 2 -> no new spawns. Grid empties after 8 steps, Done pulse,
//     Running=0. Reset asserted mid-DRAIN -> IDLE, Grid=0 next edge.

Source files
------------

// File: rtl/arrow_spawner_pkg.sv
// Shared playfield definitions for the arrow spawner: lane count, FSM states,
// difficulty thresholds and the lane one-hot helper.
package ddr_pkg;

    localparam int unsigned LANES = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    // Spawn probability is thresh/128 against the upper seven random bits.
    function automatic logic [6:0] thresh(input logic [1:0] diff);
        case (diff)
            2'd0:    thresh = 7'd32;
            2'd1:    thresh = 7'd48;
            2'd2:    thresh = 7'd64;
            default: thresh = 7'd96;
        endcase
    endfunction

    function automatic logic [LANES-1:0] onehot4(input logic [1:0] sel);
        onehot4      = '0;
        onehot4[sel] = 1'b1;
    endfunction

endpackage

// File: rtl/arrow_spawner_tick_divider.sv
// Scroll-step pacing counter: counts enabled cycles modulo TICK_DIV and flags
// the last count of each period as a step cycle.
module tick_divider #(
    parameter int unsigned TICK_DIV = 16
) (
    input  logic Clock,
    input  logic Reset,
    input  logic En,
    input  logic Clr,
    output logic Step
);

    localparam int unsigned CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (Clr) begin
            cnt_d = '0;
        end else if (En) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign Step = En && !Clr && (cnt_q == LAST);

endmodule

// File: rtl/arrow_spawner.sv
// Turns the LFSR word into falling arrows on a 4-lane grid, scrolling one row
// toward the hit row per step and handing the departing row downstream.
module arrow_spawner
    import ddr_pkg::*;
#(
    parameter int unsigned ROWS     = 8,
    parameter int unsigned TICK_DIV = 16,
    parameter int unsigned MIN_GAP  = 2
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic [8:0]            Rand,
    input  logic                  Start,
    input  logic                  Pause,
    input  logic                  Stop,
    input  logic [1:0]            Difficulty,
    output logic [LANES*ROWS-1:0] Grid,
    output logic [LANES-1:0]      Exit,
    output logic                  ExitValid,
    output logic                  Running,
    output logic                  Done
);

    localparam int unsigned GW = (MIN_GAP > 1) ? $clog2(MIN_GAP + 1) : 1;
    localparam logic [GW-1:0] GAP_MAX = GW'(MIN_GAP);

    state_t                state_q, state_d;
    logic [LANES*ROWS-1:0] grid_q, grid_d;
    logic [LANES-1:0]      exit_q, exit_d;
    logic                  exit_valid_q, exit_valid_d;
    logic                  done_q, done_d;
    logic [GW-1:0]         gap_q, gap_d;
    logic [LANES-1:0]      spawn_row;
    logic                  spawn;
    logic                  step;
    logic                  tick_en;
    logic                  tick_clr;
    logic                  spawn_en;
    logic                  running;
    logic                  drain_done;

    tick_divider #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .Clock (Clock),
        .Reset (Reset),
        .En    (tick_en),
        .Clr   (tick_clr),
        .Step  (step)
    );

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // The drain ends on the step that leaves the grid empty, so the check
    // looks at the post-shift grid rather than the current one.
    assign drain_done = (state_q == ST_DRAIN) && step && (grid_d == '0);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (Start) state_d = ST_RUN;
            ST_RUN: begin
                if (Pause) begin
                    state_d = ST_PAUSE;
                end else if (Stop) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_PAUSE: if (!Pause) state_d = ST_RUN;
            ST_DRAIN: if (drain_done) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        tick_en  = 1'b0;
        tick_clr = 1'b0;
        spawn_en = 1'b0;
        running  = 1'b0;
        case (state_q)
            ST_IDLE:  tick_clr = 1'b1;
            ST_RUN: begin
                tick_en  = !Pause;
                spawn_en = 1'b1;
                running  = 1'b1;
            end
            ST_DRAIN: begin
                tick_en = 1'b1;
                running = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        grid_d       = grid_q;
        exit_d       = exit_q;
        exit_valid_d = 1'b0;
        gap_d        = gap_q;
        spawn        = 1'b0;
        spawn_row    = '0;
        if (step) begin
            spawn = spawn_en && (Rand[8:2] < thresh(Difficulty)) && (gap_q >= GAP_MAX);
            if (spawn) begin
                spawn_row = onehot4(Rand[1:0]);
                gap_d     = GW'(1);
            end else if (gap_q < GAP_MAX) begin
                gap_d = gap_q + GW'(1);
            end
            exit_d       = grid_q[LANES-1:0];
            exit_valid_d = 1'b1;
            grid_d       = {spawn_row, grid_q[LANES*ROWS-1:LANES]};
        end
    end

    assign done_d = drain_done;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            grid_q       <= '0;
            exit_q       <= '0;
            exit_valid_q <= 1'b0;
            done_q       <= 1'b0;
            gap_q        <= GAP_MAX;
        end else begin
            grid_q       <= grid_d;
            exit_q       <= exit_d;
            exit_valid_q <= exit_valid_d;
            done_q       <= done_d;
            gap_q        <= gap_d;
        end
    end

    assign Grid      = grid_q;
    assign Exit      = exit_q;
    assign ExitValid = exit_valid_q;
    assign Running   = running;
    assign Done      = done_q;

endmodule

// File: tb/tb_arrow_spawner.sv
// Self-checking bench for arrow_spawner: a behavioural playfield model checked
// every cycle, a spawn-threshold vector table, and scripted corner sequences.
module tb_arrow_spawner;

    localparam int ROWS     = 8;
    localparam int TICK_DIV = 16;
    localparam int MIN_GAP  = 2;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_DRAIN = 3;

    logic              Clock = 1'b0;
    logic              Reset;
    logic [8:0]        Rand;
    logic              Start;
    logic              Pause;
    logic              Stop;
    logic [1:0]        Difficulty;
    logic [4*ROWS-1:0] Grid;
    logic [3:0]        Exit;
    logic              ExitValid;
    logic              Running;
    logic              Done;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model of the playfield
    int       m_state;
    int       m_tick;
    int       m_gap;
    logic [3:0] m_row [ROWS];
    logic [3:0] m_exit;
    logic       m_exitv;
    logic       m_done;
    int         thr [4] = '{32, 48, 64, 96};

    typedef struct {
        logic [8:0] rnd;
        logic [1:0] diff;
        logic [3:0] row;
    } vec_t;
    vec_t vecs [10];

    arrow_spawner #(
        .ROWS     (ROWS),
        .TICK_DIV (TICK_DIV),
        .MIN_GAP  (MIN_GAP)
    ) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .Rand       (Rand),
        .Start      (Start),
        .Pause      (Pause),
        .Stop       (Stop),
        .Difficulty (Difficulty),
        .Grid       (Grid),
        .Exit       (Exit),
        .ExitValid  (ExitValid),
        .Running    (Running),
        .Done       (Done)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = M_IDLE;
        m_tick  = 0;
        m_gap   = MIN_GAP;
        m_exit  = '0;
        m_exitv = 1'b0;
        m_done  = 1'b0;
        for (int r = 0; r < ROWS; r++) m_row[r] = '0;
    endtask

    task automatic model_clock();
        bit         active;
        bit         stepping;
        bit         empty;
        logic [3:0] nrow;
        if (Reset) begin
            model_reset();
            return;
        end
        m_done   = 1'b0;
        m_exitv  = 1'b0;
        active   = (m_state == M_RUN && !Pause) || m_state == M_DRAIN;
        stepping = active && (m_tick == TICK_DIV - 1);
        if (active) m_tick = (m_tick + 1) % TICK_DIV;
        if (stepping) begin
            nrow = '0;
            if (m_state == M_RUN && int'(Rand >> 2) < thr[Difficulty] && m_gap >= MIN_GAP) begin
                nrow[Rand[1:0]] = 1'b1;
                m_gap = 1;
            end else if (m_gap < MIN_GAP) begin
                m_gap = m_gap + 1;
            end
            m_exit  = m_row[0];
            m_exitv = 1'b1;
            for (int r = 0; r < ROWS - 1; r++) m_row[r] = m_row[r+1];
            m_row[ROWS-1] = nrow;
        end
        empty = 1'b1;
        for (int r = 0; r < ROWS; r++) if (m_row[r] != 4'd0) empty = 1'b0;
        case (m_state)
            M_IDLE:  if (Start) begin m_state = M_RUN; m_tick = 0; end
            M_RUN:   if (Pause) m_state = M_PAUSE; else if (Stop) m_state = M_DRAIN;
            M_PAUSE: if (!Pause) m_state = M_RUN;
            default: if (stepping && empty) begin m_state = M_IDLE; m_done = 1'b1; end
        endcase
    endtask

    function automatic logic [38:0] model_pack();
        logic [4*ROWS-1:0] g;
        for (int r = 0; r < ROWS; r++) g[r*4 +: 4] = m_row[r];
        return {g, m_exit, m_exitv, (m_state == M_RUN || m_state == M_DRAIN), m_done};
    endfunction

    task automatic tick();
        @(posedge Clock);
        model_clock();
        #1;
        check("model", {Grid, Exit, ExitValid, Running, Done}, model_pack());
    endtask

    task automatic run_steps(input int n);
        repeat (n * TICK_DIV) tick();
    endtask

    task automatic restart(input logic [8:0] rnd, input logic [1:0] diff);
        Reset = 1'b1; tick(); Reset = 1'b0;
        Rand = rnd; Difficulty = diff;
        Start = 1'b1; tick(); Start = 1'b0;
    endtask

    initial begin
        Reset = 1'b1; Start = 1'b0; Pause = 1'b0; Stop = 1'b0;
        Rand = '0; Difficulty = '0;
        model_reset();
        vecs[0] = '{9'h003, 2'd3, 4'b1000};
        vecs[1] = '{9'h080, 2'd0, 4'b0000};
        vecs[2] = '{9'h07C, 2'd0, 4'b0001};
        vecs[3] = '{9'h0BD, 2'd1, 4'b0010};
        vecs[4] = '{9'h0C2, 2'd1, 4'b0000};
        vecs[5] = '{9'h0FE, 2'd2, 4'b0100};
        vecs[6] = '{9'h100, 2'd2, 4'b0000};
        vecs[7] = '{9'h17F, 2'd3, 4'b1000};
        vecs[8] = '{9'h180, 2'd3, 4'b0000};
        vecs[9] = '{9'h1FF, 2'd3, 4'b0000};

        repeat (3) tick();
        Reset = 1'b0;
        tick();
        check("reset_outputs", {Grid, Exit, ExitValid, Running, Done}, 64'd0);
        for (int i = 0; i < 6; i++) begin
            Rand = 9'($urandom);
            tick();
        end
        check("idle_grid", Grid, 64'd0);

        for (int v = 0; v < 10; v++) begin
            restart(vecs[v].rnd, vecs[v].diff);
            repeat (TICK_DIV - 1) tick();
            check("pre_first_step", Grid, 64'd0);
            tick();
            check("spawn_vec", Grid, {vecs[v].row, 28'd0});
            check("first_exit_valid", ExitValid, 64'd1);
        end

        // Arrow travels the full grid and exits on the ninth step
        restart(9'h003, 2'd3);
        run_steps(1);
        Rand = 9'h1FF;
        run_steps(7);
        check("arrow_at_row0", Grid, 64'h0000_0008);
        run_steps(1);
        check("exit_lane", Exit, 64'h8);
        check("exit_valid", ExitValid, 64'd1);
        check("grid_empty_after_exit", Grid, 64'd0);
        tick();
        check("exit_valid_pulse", ExitValid, 64'd0);
        check("exit_hold", Exit, 64'h8);

        // Minimum gap forces every other step to stay empty
        restart(9'h000, 2'd0);
        run_steps(4);
        check("gap_pattern", Grid, 64'h0101_0000);
        repeat (5) tick();
        Pause = 1'b1;
        repeat (40) tick();
        check("pause_frozen", Grid, 64'h0101_0000);
        check("pause_not_running", Running, 64'd0);
        Pause = 1'b0;
        repeat (11) tick();
        check("resume_before_step", Grid, 64'h0101_0000);
        tick();
        check("resume_step", Grid, 64'h1010_1000);

        // Drain with arrows in rows 7 and 2
        restart(9'h000, 2'd3);
        run_steps(1);
        Rand = 9'h1FF;
        run_steps(4);
        Rand = 9'h003;
        run_steps(1);
        check("drain_setup", Grid, 64'h8000_0100);
        Stop = 1'b1; Rand = 9'h000;
        tick();
        Stop = 1'b0;
        repeat (8 * TICK_DIV - 2) tick();
        check("drain_last_arrow", Grid, 64'h0000_0008);
        check("drain_running", Running, 64'd1);
        tick();
        check("drain_empty", Grid, 64'd0);
        check("drain_done", Done, 64'd1);
        check("drain_stopped", Running, 64'd0);
        tick();
        check("done_pulse", Done, 64'd0);

        // Stop left high in idle, then reset in the middle of a drain
        Stop = 1'b1;
        repeat (4) tick();
        check("stop_idle", Running, 64'd0);
        Stop = 1'b0;
        Rand = 9'h000; Start = 1'b1; tick(); Start = 1'b0;
        run_steps(1);
        Stop = 1'b1; tick(); Stop = 1'b0;
        repeat (20) tick();
        Reset = 1'b1; tick(); Reset = 1'b0;
        check("reset_mid_drain", {Grid, ExitValid, Running}, 64'd0);

        for (int c = 0; c < 4000; c++) begin
            Rand       = 9'($urandom);
            Difficulty = 2'($urandom);
            Start      = ($urandom_range(0, 15) == 0);
            Reset      = ($urandom_range(0, 499) == 0);
            if ($urandom_range(0, 49) == 0) Pause = ~Pause;
            if ($urandom_range(0, 79) == 0) Stop = ~Stop;
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
